ysyx_22041461_ifu: RTL and testbench

Instruction fetch unit for the ysyx_22041461 core. Holds the program counter, issues one 32-bit instruction read per fetch over a valid/ready request and valid-only response memory interface, and presents the fetched instruction plus its PC to the decode stage through a valid/ready handshake. Accepts PC redirects from execute at any point and discards any fetch that is in flight when a redirect occurs.

---
 rtl/ysyx_22041461_ifu.sv | 124 ++++++++++++
 tb/tb_ysyx_22041461_ifu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: owns the PC, issues one 32-bit fetch at a time and
// hands the instruction plus its PC to decode over a valid/ready handshake.
//
// state  | meaning
// S_REQ  | presenting a fetch request at pc
// S_WAIT | request accepted, waiting for the response pulse
// S_OUT  | fetched instruction held for decode
module ysyx_22041461_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] target_pc;
  logic        unused_redirect_lsbs;

  // Redirect targets are always word aligned; the low bits carry no meaning.
  assign target_pc            = {redirect_pc[63:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request valid is gated by rst so nothing is issued while reset is held,
  // and drops combinationally when execute redirects in the same cycle.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_en && !rst;
  assign imem_req_addr  = {pc_q[63:2], 2'b00};
  assign inst_valid     = (state_q == S_OUT) && !rst;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_cnt      = fetch_cnt_q;

  // Next-state, PC and holding-register update logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_en) begin
          pc_d = target_pc;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect_en) begin
            // Response belongs to a squashed fetch; refetch from current pc.
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_en) pc_d = target_pc;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 64'd4;
            state_d   = S_OUT;
          end
        end else if (redirect_en) begin
          pc_d   = target_pc;
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          fetch_cnt_d = fetch_cnt_q + 64'd1;
          state_d     = S_REQ;
          if (redirect_en) pc_d = target_pc;
        end else if (redirect_en) begin
          pc_d    = target_pc;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      inst_q      <= 32'd0;
      inst_pc_q   <= 64'd0;
      fetch_cnt_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Directed bench for the fetch unit: the bench plays memory and decode,
// driving inputs 1 time unit after each rising edge and checking outputs
// before the next edge.
module tb_ysyx_22041461_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  ysyx_22041461_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle;
    #1;
  endtask

  // One complete fetch with a 1-cycle response and immediate decode accept.
  task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data);
    settle();
    check_eq("req_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("req_addr", imem_req_addr, addr);
    tick();
    check_eq("wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check_eq("wait_inst_valid", {63'd0, inst_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    settle();
    check_eq("out_inst_valid", {63'd0, inst_valid}, 64'd1);
    check_eq("out_inst", {32'd0, inst}, {32'd0, data});
    check_eq("out_inst_pc", inst_pc, addr);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    inst_ready      = 1'b0;
    redirect_en     = 1'b0;
    redirect_pc     = 64'd0;
    tick();
    tick();
    check_eq("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check_eq("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check_eq("rst_fetch_cnt", fetch_cnt, 64'd0);
    check_eq("rst_inst_pc", inst_pc, 64'd0);
    check_eq("rst_inst", {32'd0, inst}, 64'd0);

    // sequential fetch
    rst = 1'b0;
    fetch_one(64'h8000_0000, 32'h0000_0013);
    fetch_one(64'h8000_0004, 32'h0010_0093);
    fetch_one(64'h8000_0008, 32'h0020_0113);
    check_eq("seq_fetch_cnt", fetch_cnt, 64'd3);

    // decode backpressure for 5 cycles
    settle();
    check_eq("bp_req_addr", imem_req_addr, 64'h8000_000C);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0030_0193;
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
      check_eq("bp_inst", {32'd0, inst}, 64'h0030_0193);
      check_eq("bp_inst_pc", inst_pc, 64'h8000_000C);
      check_eq("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
      tick();
    end
    check_eq("bp_cnt_hold", fetch_cnt, 64'd3);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_eq("bp_cnt", fetch_cnt, 64'd4);
    settle();
    check_eq("bp_next_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("bp_next_addr", imem_req_addr, 64'h8000_0010);

    // redirect while waiting, response two cycles later is discarded
    tick();
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0103;
    tick();
    redirect_en = 1'b0;
    settle();
    check_eq("rw_inst_valid1", {63'd0, inst_valid}, 64'd0);
    check_eq("rw_req_valid1", {63'd0, imem_req_valid}, 64'd0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check_eq("rw_inst_valid2", {63'd0, inst_valid}, 64'd0);
    check_eq("rw_cnt", fetch_cnt, 64'd4);
    fetch_one(64'h8000_0100, 32'h0040_0213);
    check_eq("rw_cnt_after", fetch_cnt, 64'd5);

    // redirect coincident with decode handshake
    settle();
    check_eq("rh_req_addr", imem_req_addr, 64'h8000_0104);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0050_0293;
    tick();
    imem_resp_valid = 1'b0;
    inst_ready  = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0200;
    tick();
    inst_ready  = 1'b0;
    redirect_en = 1'b0;
    check_eq("rh_cnt", fetch_cnt, 64'd6);
    settle();
    check_eq("rh_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("rh_req_addr2", imem_req_addr, 64'h8000_0200);

    // redirect in S_OUT without ready drops the instruction
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0060_0313;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check_eq("rd_inst_valid", {63'd0, inst_valid}, 64'd1);
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0300;
    tick();
    redirect_en = 1'b0;
    settle();
    check_eq("rd_inst_valid_drop", {63'd0, inst_valid}, 64'd0);
    check_eq("rd_cnt", fetch_cnt, 64'd6);
    check_eq("rd_req_addr", imem_req_addr, 64'h8000_0300);

    // redirect in S_REQ suppresses the request; low target bits ignored
    redirect_en = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    settle();
    check_eq("rq_req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick();
    redirect_en = 1'b0;
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h0070_0393);
    check_eq("wrap_cnt", fetch_cnt, 64'd7);
    settle();
    check_eq("wrap_req_addr", imem_req_addr, 64'd0);

    // reset while waiting, stale response right after release
    tick();
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    settle();
    check_eq("rs_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("rs_req_addr", imem_req_addr, 64'h8000_0000);
    check_eq("rs_cnt", fetch_cnt, 64'd0);
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check_eq("rs_inst_valid", {63'd0, inst_valid}, 64'd0);
    check_eq("rs_req_valid2", {63'd0, imem_req_valid}, 64'd1);
    imem_req_ready = 1'b1;
    fetch_one(64'h8000_0000, 32'h0000_0013);
    check_eq("rs_cnt_after", fetch_cnt, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
